// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory loader: FSM encoding and the
// default NOP word returned for unserviced fetches.
package instr_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } ldr_state_t;

   localparam logic [31:0] NOP_DEFAULT = 32'h6C00_0000;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous write port, one registered read port.
// Contents are never cleared; the loader tracks which words are valid.
module instr_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clock,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      // rd_data holds whenever no fetch is serviced
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/instruction_memory_loader.sv
// Loads a program word-by-word into instruction RAM and serves 1-cycle fetches
// once a complete program is resident.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no program resident (after reset or an overflowed load)
//   ST_LOAD  | accepting load words at the write pointer
//   ST_READY | complete program resident, fetches below word_count served
module instruction_memory_loader
   import instr_mem_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DEPTH      = 1024,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = NOP_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  load_ready,
   input  logic                  fetch_en,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] iRAMOutput,
   output logic                  fetch_valid,
   output logic                  program_ready,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  load_error
);

   localparam logic [ADDR_WIDTH:0] DEPTH_PTR = (ADDR_WIDTH+1)'(DEPTH);

   ldr_state_t              state;
   logic [ADDR_WIDTH:0]     wr_ptr;
   logic                    accept;
   logic                    overflow;
   logic                    wr_en;
   logic                    serve;
   logic [DATA_WIDTH-1:0]   rd_data;

   assign load_ready = (state == ST_LOAD);

   // load_start takes priority over a word presented in the same cycle
   assign accept   = load_ready && load_valid && !load_start;
   assign overflow = accept && (wr_ptr == DEPTH_PTR);
   assign wr_en    = accept && !overflow;

   assign serve = fetch_en && !load_start && (state == ST_READY) &&
                  ({1'b0, address} < wr_ptr);

   // Every accepted in-range word advances the pointer, so it doubles as the count
   assign word_count = wr_ptr;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         wr_ptr        <= '0;
         program_ready <= 1'b0;
         load_error    <= 1'b0;
         fetch_valid   <= 1'b0;
      end else begin
         if (load_start) begin
            state         <= ST_LOAD;
            wr_ptr        <= '0;
            program_ready <= 1'b0;
            load_error    <= 1'b0;
         end else if (accept) begin
            if (overflow) begin
               state         <= ST_IDLE;
               load_error    <= 1'b1;
               program_ready <= 1'b0;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
               if (load_last) begin
                  state         <= ST_READY;
                  program_ready <= 1'b1;
               end
            end
         end

         if (fetch_en) begin
            fetch_valid <= serve;
         end
      end
   end

   // fetch_valid and rd_data are both registered, so the output is still a
   // registered value; unserviced fetches substitute the NOP word
   assign iRAMOutput = fetch_valid ? rd_data : NOP_WORD;

   instr_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
      .wr_data (load_data),
      .rd_en   (serve),
      .rd_addr (address),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Scoreboard bench for instruction_memory_loader: a default-size instance for
// load/fetch behaviour and a DEPTH=4 instance for overflow.
module tb_instruction_memory_loader;

   localparam logic [31:0] NOP = 32'h6C00_0000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        load_start = 1'b0;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = '0;
   logic        load_last = 1'b0;
   logic        load_ready;
   logic        fetch_en = 1'b0;
   logic [9:0]  address = '0;
   logic [31:0] iRAMOutput;
   logic        fetch_valid;
   logic        program_ready;
   logic [10:0] word_count;
   logic        load_error;

   logic        start4 = 1'b0;
   logic        fetch4 = 1'b0;
   logic [1:0]  addr4 = '0;
   logic        ready4;
   logic [31:0] out4;
   logic        fv4;
   logic        pr4;
   logic [2:0]  wc4;
   logic        err4;

   typedef struct {
      logic [31:0] data;
      logic        valid;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clock = ~clock;

   instruction_memory_loader dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .load_start    (load_start),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_last     (load_last),
      .load_ready    (load_ready),
      .fetch_en      (fetch_en),
      .address       (address),
      .iRAMOutput    (iRAMOutput),
      .fetch_valid   (fetch_valid),
      .program_ready (program_ready),
      .word_count    (word_count),
      .load_error    (load_error)
   );

   instruction_memory_loader #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (2),
      .DEPTH      (4)
   ) dut4 (
      .clock         (clock),
      .reset_n       (reset_n),
      .load_start    (start4),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_last     (load_last),
      .load_ready    (ready4),
      .fetch_en      (fetch4),
      .address       (addr4),
      .iRAMOutput    (out4),
      .fetch_valid   (fv4),
      .program_ready (pr4),
      .word_count    (wc4),
      .load_error    (err4)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // Monitor: every sampled fetch yields one output to compare one cycle later
   always @(posedge clock) begin
      if (fetch_en) begin : mon
         exp_t e;
         #1;
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL fetch_unexpected: got %h, want no fetch", iRAMOutput);
         end else begin
            e = exp_q.pop_front();
            check("fetch_data", iRAMOutput, e.data);
            check("fetch_valid", 32'(fetch_valid), 32'(e.valid));
         end
      end
   end

   task automatic step(input logic st, input logic v, input logic [31:0] d, input logic l,
                       input logic fe, input logic [9:0] a, input logic st4);
      @(negedge clock);
      load_start = st;
      load_valid = v;
      load_data  = d;
      load_last  = l;
      fetch_en   = fe;
      address    = a;
      start4     = st4;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b0);
   endtask

   task automatic fetch(input logic [9:0] a, input logic [31:0] ed, input logic ev);
      exp_q.push_back('{ed, ev});
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, a, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n    = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
      fetch_en   = 1'b0;
      start4     = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state and fetch before any load
      do_reset();
      check("rst_iram", iRAMOutput, NOP);
      check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      check("rst_load_ready", 32'(load_ready), 32'd0);
      check("rst_word_count", 32'(word_count), 32'd0);
      check("rst_load_error", 32'(load_error), 32'd0);
      fetch(10'd0, NOP, 1'b0);
      idle();
      check("rst_program_ready", 32'(program_ready), 32'd0);

      // 12-word program 0x100..0x10B
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1, 32'h100 + 32'(i), (i == 11), 1'b0, 10'd0, 1'b0);
         if (i == 0) begin
            check("load_ready_in_load", 32'(load_ready), 32'd1);
            check("wc_after_start", 32'(word_count), 32'd0);
         end
      end
      idle();
      check("p12_program_ready", 32'(program_ready), 32'd1);
      check("p12_word_count", 32'(word_count), 32'd12);
      check("p12_load_ready", 32'(load_ready), 32'd0);
      fetch(10'd5, 32'h105, 1'b1);
      fetch(10'd12, NOP, 1'b0);
      fetch(10'd0, 32'h100, 1'b1);
      fetch(10'd11, 32'h10B, 1'b1);
      idle();
      idle();
      check("hold_iram", iRAMOutput, 32'h10B);
      check("hold_fetch_valid", 32'(fetch_valid), 32'd1);

      // reset in the middle of a 6-word load, then a fresh 2-word load
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 10'd0, 1'b0);
      end
      do_reset();
      check("abort_program_ready", 32'(program_ready), 32'd0);
      check("abort_word_count", 32'(word_count), 32'd0);
      check("abort_iram", iRAMOutput, NOP);
      fetch(10'd0, NOP, 1'b0);
      fetch(10'd2, NOP, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b0);
      step(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 10'd0, 1'b0);
      step(1'b0, 1'b1, 32'h301, 1'b1, 1'b0, 10'd0, 1'b0);
      idle();
      check("p2_program_ready", 32'(program_ready), 32'd1);
      check("p2_word_count", 32'(word_count), 32'd2);
      fetch(10'd0, 32'h300, 1'b1);
      fetch(10'd1, 32'h301, 1'b1);
      fetch(10'd2, NOP, 1'b0);

      // load_valid gaps, with a fetch issued during LOAD
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b0);
      step(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 10'd0, 1'b0);
      exp_q.push_back('{NOP, 1'b0});
      step(1'b0, 1'b0, 32'hDEAD, 1'b0, 1'b1, 10'd0, 1'b0);
      step(1'b0, 1'b1, 32'h401, 1'b0, 1'b0, 10'd0, 1'b0);
      step(1'b0, 1'b0, 32'hBEEF, 1'b0, 1'b0, 10'd0, 1'b0);
      check("gap_word_count", 32'(word_count), 32'd2);
      check("gap_program_ready", 32'(program_ready), 32'd0);
      step(1'b0, 1'b1, 32'h402, 1'b1, 1'b0, 10'd0, 1'b0);
      idle();
      check("gap_final_count", 32'(word_count), 32'd3);
      fetch(10'd1, 32'h401, 1'b1);
      fetch(10'd2, 32'h402, 1'b1);

      // load_start with fetch and load_valid in the same cycle
      exp_q.push_back('{NOP, 1'b0});
      step(1'b1, 1'b1, 32'hBAD, 1'b0, 1'b1, 10'd0, 1'b0);
      step(1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 10'd0, 1'b0);
      check("prio_load_ready", 32'(load_ready), 32'd1);
      check("prio_word_count", 32'(word_count), 32'd0);
      check("prio_program_ready", 32'(program_ready), 32'd0);
      idle();
      check("prio_final_count", 32'(word_count), 32'd1);
      check("prio_final_ready", 32'(program_ready), 32'd1);
      fetch(10'd0, 32'h500, 1'b1);
      fetch(10'd1, NOP, 1'b0);

      // DEPTH=4 overflow on the second instance
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 32'h600 + 32'(i), 1'b0, 1'b0, 10'd0, 1'b0);
      end
      check("d4_full_count", 32'(wc4), 32'd4);
      check("d4_full_error", 32'(err4), 32'd0);
      check("d4_full_ready", 32'(ready4), 32'd1);
      idle();
      check("d4_ovf_error", 32'(err4), 32'd1);
      check("d4_ovf_ready", 32'(ready4), 32'd0);
      check("d4_ovf_program_ready", 32'(pr4), 32'd0);
      check("d4_mem3", dut4.u_mem.mem[3], 32'h603);
      check("d4_mem0", dut4.u_mem.mem[0], 32'h600);
      check("d4_main_untouched", 32'(word_count), 32'd1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b1);
      idle();
      check("d4_restart_error", 32'(err4), 32'd0);
      check("d4_restart_ready", 32'(ready4), 32'd1);
      check("d4_iram", out4, NOP);
      check("d4_fetch_valid", 32'(fv4), 32'd0);

      idle();
      idle();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
